// File: rtl/parallel_send.sv
// Purpose : PRBS link-test transmitter: training preamble, SYNC pulse to arm the
//           far-end checker, then a burst of lfsr32x2 words with optional one-word error injection.
// Latency : 1 cycle from an accepted push (PRE/BURST with DORDY=1) to DOPUSH/DOUT.
// Backpr. : DORDY=0 stalls the FSM, the word counters and the LFSR in PRE/BURST.
//           SYNC and GAP always advance.
// Ports   : CLK, RSTX (async, active-low), CLR (sync clear), START, DORDY,
//           ERR_INJ/ERR_MASK (inject request and mask),
//           DOPUSH/DOUT (registered word), SYNC, BUSY, SENT_CNT, INJ_CNT.
module parallel_send #(
    parameter int          BURST_LEN  = 1024,
    parameter int          PRE_LEN    = 16,
    parameter logic [31:0] TRAIN_WORD = 32'h0000_FFFF
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        CLR,
    input  logic        START,
    input  logic        DORDY,
    input  logic        ERR_INJ,
    input  logic [31:0] ERR_MASK,
    output logic        DOPUSH,
    output logic [31:0] DOUT,
    output logic        SYNC,
    output logic        BUSY,
    output logic [57:0] SENT_CNT,
    output logic [15:0] INJ_CNT
);

    localparam int BCW = $clog2(BURST_LEN + 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);
    localparam logic [15:0]    PRE_LAST   = 16'(PRE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_GAP,
        S_BURST
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     pre_cnt;
    logic [BCW-1:0]  burst_cnt;
    logic [31:0]     pat;
    logic            inj_pend;
    logic [31:0]     inj_mask;

    logic            push;
    logic            burst_push;
    logic            inj_apply;
    logic [31:0]     word;

    // Two XNOR Fibonacci steps (taps 32,22,2,1). The all-zero seed is a
    // legal state for XNOR feedback, so P can start at 0.
    function automatic logic [31:0] lfsr32x2(input logic [31:0] p);
        logic [31:0] s1;
        s1 = {p[30:0], ~(p[31] ^ p[21] ^ p[1] ^ p[0])};
        return {s1[30:0], ~(s1[31] ^ s1[21] ^ s1[1] ^ s1[0])};
    endfunction

    assign push       = DORDY && ((state == S_PRE) || (state == S_BURST));
    assign burst_push = DORDY && (state == S_BURST);
    assign inj_apply  = burst_push && inj_pend;
    assign word       = (state == S_PRE) ? TRAIN_WORD
                                         : (pat ^ (inj_apply ? inj_mask : 32'd0));
    assign BUSY       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_PRE;
            S_PRE:   if (DORDY && (pre_cnt == PRE_LAST)) state_nxt = S_SYNC;
            S_SYNC:  state_nxt = S_GAP;
            S_GAP:   state_nxt = S_BURST;
            S_BURST: if (DORDY && (burst_cnt == BURST_LAST)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state <= S_IDLE;
        end else if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word counters, pattern state, injection bookkeeping and registered outputs.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            pre_cnt   <= '0;
            burst_cnt <= '0;
            pat       <= '0;
            inj_pend  <= 1'b0;
            inj_mask  <= '0;
            DOPUSH    <= 1'b0;
            DOUT      <= '0;
            SYNC      <= 1'b0;
            SENT_CNT  <= '0;
            INJ_CNT   <= '0;
        end else if (CLR) begin
            pre_cnt   <= '0;
            burst_cnt <= '0;
            pat       <= '0;
            inj_pend  <= 1'b0;
            inj_mask  <= '0;
            DOPUSH    <= 1'b0;
            DOUT      <= '0;
            SYNC      <= 1'b0;
            SENT_CNT  <= '0;
            INJ_CNT   <= '0;
        end else begin
            DOPUSH <= push;
            // SYNC is registered so it sits in the output stream between the last
            // preamble strobe and the gap cycle.
            SYNC   <= (state == S_SYNC);
            if (push) begin
                DOUT <= word;
            end

            if (state == S_PRE && DORDY) begin
                pre_cnt <= (pre_cnt == PRE_LAST) ? 16'd0 : pre_cnt + 16'd1;
            end else if (state == S_IDLE) begin
                pre_cnt <= '0;
            end

            if (burst_push) begin
                burst_cnt <= (burst_cnt == BURST_LAST) ? '0 : burst_cnt + 1'b1;
                // The uncorrupted value feeds the LFSR so the far-end reference stays in step.
                pat       <= lfsr32x2(pat);
                if (~&SENT_CNT) begin
                    SENT_CNT <= SENT_CNT + 58'd1;
                end
            end else if (state == S_IDLE) begin
                burst_cnt <= '0;
            end

            // A new request always wins. If it lands on a burst push, that push
            // consumes the old request and the new one waits for the next word.
            if (ERR_INJ) begin
                inj_pend <= 1'b1;
                inj_mask <= ERR_MASK;
            end else if (inj_apply) begin
                inj_pend <= 1'b0;
            end
            if (inj_apply && (~&INJ_CNT)) begin
                INJ_CNT <= INJ_CNT + 16'd1;
            end
        end
    end

endmodule

// File: doc/parallel_send.md
# parallel_send

Parallel PRBS pattern transmitter for the 32-bit link-test path. On START it emits a training preamble, pulses SYNC to arm the far-end checker's window, then pushes a burst of pseudo-random words generated with the existing `lfsr32x2` next-word function. It sits at the transmit end of the link, ahead of the serializer/aligner that feeds the checker. It also supports on-demand error injection so the far-end error counter can be exercised.

## Interface
- BURST_LEN, 1024, pattern words per burst; must equal the checker window length.
- PRE_LEN, 16, training words sent before SYNC; legal range 1..65535.
- TRAIN_WORD, 32'h0000_FFFF, word sent during the preamble.

- RSTX  in  1  reset, asynchronous, active-low
- CLK  in  1  clock
- CLR  in  1  synchronous clear: return to IDLE, zero all state and counters
- START  in  1  pulse; begins a sequence when IDLE, ignored otherwise
- DORDY  in  1  downstream can accept a word this cycle
- ERR_INJ  in  1  pulse; request corruption of one burst word
- ERR_MASK  in  32  XOR mask applied to the corrupted word, sampled with ERR_INJ
- DOPUSH  out  1  registered word strobe
- DOUT  out  32  registered word, valid when DOPUSH=1
- SYNC  out  1  one-cycle pulse that drives the checker INIT
- BUSY  out  1  high in any state other than IDLE
- SENT_CNT  out  58  burst words pushed, saturating
- INJ_CNT  out  16  corrupted words pushed, saturating

## Operation
- FSM states and transitions:
  - IDLE → PRE on START.
  - PRE → SYNC after PRE_LEN words have been pushed.
  - SYNC → GAP after 1 cycle.
  - GAP → BURST after 1 cycle.
  - BURST → IDLE after BURST_LEN words have been pushed.
- A push occurs only in PRE or BURST, and only in a cycle where DORDY=1.
  - The push appears as DOPUSH=1 with DOUT on the following cycle; DOPUSH is 0 otherwise.
  - DORDY=0 stalls the FSM, the word counters, and the LFSR.
- PRE: DOUT=TRAIN_WORD.
- SYNC: SYNC=1 and DOPUSH=0.
- GAP: DOPUSH=0.
  - SYNC and GAP take no part in the handshake and are not stalled by DORDY.
- BURST: DOUT = pattern word P XOR (mask if an injection is applied to this word, else 0).
  - After each burst push, P ← lfsr32x2(P). The LFSR advances with the uncorrupted value.
  - P resets to 32'd0 only on RSTX or CLR. The sequence continues across bursts, matching the checker's reference, which is not re-seeded by INIT.
- Injection:
  - ERR_INJ sets a pending flag and latches ERR_MASK.
  - The next burst push applies the mask, clears the flag, and increments INJ_CNT.
  - ERR_INJ while a request is already pending overwrites the mask; the two requests count as one.
  - A pending request survives through IDLE/PRE until the next burst push.
  - ERR_INJ in the same cycle as a burst push is applied to the following burst word.
- SENT_CNT increments by 1 per burst push and saturates at all-ones. INJ_CNT saturates at 16'hFFFF.
- CLR has priority over every other input. RSTX/CLR mid-burst aborts immediately with no partial completion.

## Timing
- Reset/CLR values:
  - DOPUSH=0, DOUT=0, SYNC=0, BUSY=0, SENT_CNT=0, INJ_CNT=0.
  - P=0, pending flag cleared, state IDLE.
- START sampled at edge t: BUSY=1 from cycle t+1. The first preamble DOPUSH comes the cycle after the first DORDY=1 sampled in PRE.
- With DORDY held high, the first burst DOPUSH is exactly 2 cycles after the SYNC cycle. This meets the checker's one-cycle INIT pipeline.
- Last burst push in cycle n: BUSY=0 in cycle n+1. START in cycle n+1 is accepted.
- Minimum sequence length with DORDY=1: PRE_LEN+BURST_LEN+3 cycles from START to BUSY low.

## Test plan
- Reset, DORDY=1, START:
  - 16 pushes of 32'h0000FFFF.
  - SYNC pulse, then 1 idle cycle.
  - 1024 pushes; first DOUT=0, second=lfsr32x2(0).
  - SENT_CNT=1024, BUSY low afterwards.
- Two back-to-back bursts: first word of burst 2 = lfsr32x2 applied 1024 times to 0. Checker driven by SYNC reports ERR_CNT=0 and RECV_CNT=2048.
- DORDY toggled randomly at 50% during a burst: DOUT sequence identical to the DORDY=1 case, no duplicated or skipped words, SENT_CNT=1024.
- ERR_INJ with ERR_MASK=32'h0000_0007 in IDLE, then START: only burst word 0 equals 32'h7. Later words are unaffected. INJ_CNT=1; checker ERR_CNT=3.
- CLR mid-burst (after 500 words), then START: state IDLE, counters 0. The new burst starts at P=0; SYNC and the preamble repeat.
- START during BUSY and during SYNC/GAP: ignored, with no change to the word count or to the SYNC pulse count.
